// File: rtl/uart_rx_device_pkg.sv
// Shared encodings for the UART receiver peripheral: FSM states, register
// offsets and status bit positions.
package uart_rx_device_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam logic [1:0] REG_RX_DATA   = 2'd0;
  localparam logic [1:0] REG_RX_STATUS = 2'd1;

  localparam int STAT_VALID = 0;
  localparam int STAT_OVR   = 1;
  localparam int STAT_FERR  = 2;

endpackage

// File: rtl/uart_rx_device_if.sv
// CPU-side read port of the UART receiver: strobe, register select, read data, irq.
interface uart_rx_device_if;
  logic        rd;
  logic [1:0]  addr;
  logic [31:0] rdata;
  logic        rx_irq;

  modport master (output rd, output addr, input rdata, input rx_irq);
  modport slave  (input rd, input addr, output rdata, output rx_irq);
endinterface

// File: rtl/uart_rx_device_core.sv
// 8N1 deserialiser: 2-flop synchroniser, mid-bit sampling FSM, LSB-first shift
// register. Emits one-cycle byte_done / frame_err pulses at the stop-bit sample.
module uart_rx_core
  import uart_rx_device_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604,
  parameter int CNT_W        = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_done,
  output logic       o_frame_err
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_sync1, r_rx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_sync1   <= i_rx;
      r_rx_s    <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    o_byte_done   = 1'b0;
    o_frame_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_s) w_state_nxt = ST_START;
      end
      ST_START: begin
        // A line that is high again at mid-bit was only a glitch.
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = r_rx_s ? ST_IDLE : ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt              = '0;
          w_shift_nxt[r_bit_idx] = r_rx_s;
          if (r_bit_idx == 3'd7) w_state_nxt   = ST_STOP;
          else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt = '0;
          if (r_rx_s) begin
            o_byte_done = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            o_frame_err = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_BREAK: begin
        if (r_rx_s) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_byte = r_shift;

endmodule

// File: rtl/uart_rx_device.sv
// Memory-mapped UART receiver: one-byte holding register, overrun/framing flags
// and a combinational read mux; the serial side lives in uart_rx_core.
module uart_rx_device
  import uart_rx_device_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604,
  parameter int CNT_W        = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  uart_rx_device_if.slave  bus
);

  logic [7:0]  w_byte;
  logic        w_byte_done, w_frame_err;
  logic        w_rd_data, w_rd_stat;
  logic [7:0]  r_data;
  logic        r_valid, r_ovr, r_ferr;
  logic [31:0] w_rdata;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_core (
    .clk         (clk),
    .reset       (reset),
    .i_rx        (rx),
    .o_byte      (w_byte),
    .o_byte_done (w_byte_done),
    .o_frame_err (w_frame_err)
  );

  assign w_rd_data = bus.rd && (bus.addr == REG_RX_DATA);
  assign w_rd_stat = bus.rd && (bus.addr == REG_RX_STATUS);

  // A commit coinciding with a data read replaces the byte the CPU just took.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_byte_done) begin
        if (!r_valid || w_rd_data) begin
          r_data  <= w_byte;
          r_valid <= 1'b1;
        end
      end else if (w_rd_data) begin
        r_valid <= 1'b0;
      end
      if (w_byte_done && r_valid && !w_rd_data) r_ovr <= 1'b1;
      else if (w_rd_stat)                       r_ovr <= 1'b0;
      if (w_frame_err)    r_ferr <= 1'b1;
      else if (w_rd_stat) r_ferr <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.addr)
      REG_RX_DATA:   w_rdata[7:0] = r_data;
      REG_RX_STATUS: begin
        w_rdata[STAT_VALID] = r_valid;
        w_rdata[STAT_OVR]   = r_ovr;
        w_rdata[STAT_FERR]  = r_ferr;
      end
      default: w_rdata = '0;
    endcase
  end

  assign bus.rdata  = w_rdata;
  assign bus.rx_irq = r_valid;

endmodule

// File: tb/tb_uart_rx_device.sv
// Directed bench for uart_rx_device at 16 clocks per bit.
module tb_uart_rx_device;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  int   checks = 0;
  int   errors = 0;

  uart_rx_device_if bus();

  uart_rx_device #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // All drives happen 1 time unit after a rising edge; samples on the falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(CPB);
    end
    rx = stop_bit;
    step(CPB);
    rx = 1'b1;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v, output logic irq);
    bus.rd   = 1'b0;
    bus.addr = a;
    @(negedge clk);
    v   = bus.rdata;
    irq = bus.rx_irq;
    step(1);
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
    bus.rd   = 1'b1;
    bus.addr = a;
    @(negedge clk);
    v = bus.rdata;
    step(1);
    bus.rd = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    logic        irq;
    reset = 1'b0; rx = 1'b1; bus.rd = 1'b0; bus.addr = 2'd0;
    step(3);
    peek(2'd0, v, irq);
    checks++; if (v !== 32'h0) begin $display("FAIL reset_data got %h exp %h", v, 32'h0); errors++; end
    peek(2'd1, v, irq);
    checks++; if (v !== 32'h0 || irq !== 1'b0) begin $display("FAIL reset_status got %h irq %b exp 0", v, irq); errors++; end
    reset = 1'b1;
    step(2);
    // start a frame and kill it mid-way with reset
    rx = 1'b0;
    step(40);
    reset = 1'b0;
    rx = 1'b1;
    step(3);
    reset = 1'b1;
    step(200);
    peek(2'd0, v, irq);
    checks++; if (v !== 32'h0) begin $display("FAIL abort_data got %h exp %h", v, 32'h0); errors++; end
    peek(2'd1, v, irq);
    checks++; if (v !== 32'h0 || irq !== 1'b0) begin $display("FAIL abort_status got %h irq %b exp 0", v, irq); errors++; end
    send_frame(8'hA5, 1'b1);
    step(4);
    peek(2'd0, v, irq);
    checks++; if (v !== 32'h000000A5) begin $display("FAIL a5_data got %h exp %h", v, 32'hA5); errors++; end
    peek(2'd1, v, irq);
    checks++; if (v !== 32'h1 || irq !== 1'b1) begin $display("FAIL a5_status got %h irq %b exp 1/1", v, irq); errors++; end
    peek(2'd2, v, irq);
    checks++; if (v !== 32'h0) begin $display("FAIL reserved_read got %h exp 0", v); errors++; end
    rd_reg(2'd0, v);
  endtask

  task automatic test_read_clear;
    logic [31:0] v;
    logic        irq;
    send_frame(8'h3C, 1'b1);
    step(4);
    rd_reg(2'd0, v);
    checks++; if (v !== 32'h3C) begin $display("FAIL rd_3c got %h exp %h", v, 32'h3C); errors++; end
    peek(2'd1, v, irq);
    checks++; if (v !== 32'h0 || irq !== 1'b0) begin $display("FAIL rd_clear got %h irq %b exp 0/0", v, irq); errors++; end
  endtask

  task automatic test_overrun;
    logic [31:0] v;
    logic        irq;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    step(4);
    peek(2'd0, v, irq);
    checks++; if (v !== 32'h11) begin $display("FAIL ovr_data got %h exp %h", v, 32'h11); errors++; end
    peek(2'd1, v, irq);
    checks++; if (v !== 32'h3) begin $display("FAIL ovr_status got %h exp %h", v, 32'h3); errors++; end
    rd_reg(2'd1, v);
    peek(2'd1, v, irq);
    checks++; if (v !== 32'h1) begin $display("FAIL ovr_cleared got %h exp %h", v, 32'h1); errors++; end
    rd_reg(2'd0, v);
  endtask

  task automatic test_frame_err;
    logic [31:0] v;
    logic        irq;
    send_frame(8'hFF, 1'b0);
    rx = 1'b0;
    step(40);
    peek(2'd1, v, irq);
    checks++; if (v !== 32'h4) begin $display("FAIL ferr_in_break got %h exp %h", v, 32'h4); errors++; end
    rx = 1'b1;
    step(5);
    peek(2'd1, v, irq);
    checks++; if (v !== 32'h4 || irq !== 1'b0) begin $display("FAIL ferr_status got %h irq %b exp 4/0", v, irq); errors++; end
    send_frame(8'h5A, 1'b1);
    step(4);
    peek(2'd0, v, irq);
    checks++; if (v !== 32'h5A) begin $display("FAIL after_ferr_data got %h exp %h", v, 32'h5A); errors++; end
    peek(2'd1, v, irq);
    checks++; if (v !== 32'h5) begin $display("FAIL after_ferr_status got %h exp %h", v, 32'h5); errors++; end
    rd_reg(2'd1, v);
    rd_reg(2'd0, v);
  endtask

  task automatic test_glitch;
    logic [31:0] v;
    logic        irq;
    rx = 1'b0;
    step(5);
    rx = 1'b1;
    step(40);
    peek(2'd1, v, irq);
    checks++; if (v !== 32'h0 || irq !== 1'b0) begin $display("FAIL glitch_status got %h irq %b exp 0/0", v, irq); errors++; end
  endtask

  task automatic test_read_commit;
    logic [31:0] v;
    logic [31:0] vr;
    logic        irq;
    send_frame(8'h66, 1'b1);
    step(4);
    // Stop-bit sample of a frame started after edge k lands on edge k+155.
    fork
      send_frame(8'h77, 1'b1);
      begin
        step(154);
        bus.rd   = 1'b1;
        bus.addr = 2'd0;
        @(negedge clk);
        vr = bus.rdata;
        step(1);
        bus.rd = 1'b0;
      end
    join
    step(4);
    checks++; if (vr !== 32'h66) begin $display("FAIL commit_read got %h exp %h", vr, 32'h66); errors++; end
    peek(2'd0, v, irq);
    checks++; if (v !== 32'h77) begin $display("FAIL commit_data got %h exp %h", v, 32'h77); errors++; end
    peek(2'd1, v, irq);
    checks++; if (v !== 32'h1 || irq !== 1'b1) begin $display("FAIL commit_status got %h irq %b exp 1/1", v, irq); errors++; end
  endtask

  initial begin
    test_reset();
    test_read_clear();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_read_commit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
